rwm_frame_ctrl: RTL and testbench

Frame sequencer for the pixel read/write memory (RWM). On a frame request it drives the RWM command lines through optional clear, capture (write, paced by the grayscaling module's valid) and readout (read) phases, and closes each phase on the RWM done pulse. It sits between the top-level controller and the RWM, inserting the mandatory enable-low gap between commands. It reports busy, frame completion and a frame counter.

---
 rtl/rwm_ctrl_pkg.sv | 25 ++
 rtl/rwm_ctrl_wdog.sv | 39 +++
 rtl/rwm_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_rwm_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rwm_ctrl_pkg.sv
// Shared state and phase encodings for the RWM frame sequencer and its watchdog.
package rwm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        GAP  = 3'd2,
        WR   = 3'd3,
        RD   = 3'd4,
        FIN  = 3'd5,
        ERR  = 3'd6
    } state_e;

    // Phase entered once the enable-low gap has elapsed.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_WR   = 2'd1,
        PH_RD   = 2'd2
    } phase_e;

    function automatic logic is_cmd_state(state_e s);
        return (s == CLR) || (s == WR) || (s == RD);
    endfunction

endpackage

// File: rtl/rwm_ctrl_wdog.sv
// Per-phase timeout counter: cleared by load_i, counts while en_i, flags expiry
// during the LIMIT-th cycle of a phase. Only instantiated under RWM_CTRL_WDOG_EN.
module rwm_ctrl_wdog
    import rwm_ctrl_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rwm_frame_ctrl.sv
// Frame sequencer driving the RWM through clear, write and read phases with an
// enable-low gap between them. Define RWM_CTRL_WDOG_EN to add the phase watchdog.
module rwm_frame_ctrl
    import rwm_ctrl_pkg::*;
#(
    parameter int CLEAR_FIRST = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8,
    parameter int WDOG_LIMIT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear_req,
    input  logic             rwm_done,
    output logic             rwm_enable,
    output logic             rwm_rw,
    output logic             rwm_clear,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             error
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e           state_q, state_d;
    phase_e           next_ph_q, next_ph_d;
    logic             clr_only_q, clr_only_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             wdog_expired;
    state_e           first_phase;

    assign first_phase = (CLEAR_FIRST != 0) ? CLR : WR;

`ifdef RWM_CTRL_WDOG_EN
    rwm_ctrl_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (!is_cmd_state(state_q)),
        .en_i     (is_cmd_state(state_q)),
        .expired_o(wdog_expired)
    );
    assign error = (state_q == ERR);
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = (WDOG_LIMIT != 0);
    assign wdog_expired      = 1'b0;
    assign error             = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        next_ph_d   = next_ph_q;
        clr_only_d  = clr_only_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                // start has priority; a simultaneous clear_req is dropped
                if (start) begin
                    state_d    = first_phase;
                    clr_only_d = 1'b0;
                end else if (clear_req) begin
                    state_d    = CLR;
                    clr_only_d = 1'b1;
                end
            end
            CLR: begin
                if (rwm_done) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    next_ph_d = clr_only_q ? PH_IDLE : PH_WR;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            WR: begin
                if (rwm_done) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    next_ph_d = PH_RD;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            RD: begin
                if (rwm_done) begin
                    state_d = FIN;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    unique case (next_ph_q)
                        PH_WR:   state_d = WR;
                        PH_RD:   state_d = RD;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            FIN: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                if (start) begin
                    state_d    = first_phase;
                    clr_only_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_ph_q   <= PH_IDLE;
            clr_only_q  <= 1'b0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            next_ph_q   <= next_ph_d;
            clr_only_q  <= clr_only_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rwm_enable  = is_cmd_state(state_q);
    assign rwm_rw      = (state_q == WR);
    assign rwm_clear   = (state_q == CLR);
    assign busy        = (state_q != IDLE) && (state_q != ERR);
    assign frame_done  = (state_q == FIN);
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_rwm_frame_ctrl.sv
// Scoreboard bench for rwm_frame_ctrl: a simple RWM model answers each enabled
// phase after LEN cycles; a monitor turns DUT activity into events for checking.
module tb_rwm_frame_ctrl;

    localparam int LEN   = 4;
    localparam int CNT_W = 2;

    localparam int K_RUN  = 1;
    localparam int K_LOW  = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    // run codes are {rwm_clear, rwm_rw}
    localparam int C_CLR = 2;
    localparam int C_WR  = 1;
    localparam int C_RD  = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clear_req = 1'b0;
    logic             rwm_done;
    logic             rwm_enable;
    logic             rwm_rw;
    logic             rwm_clear;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;
    logic             error;

    always #5 clk = ~clk;

    rwm_frame_ctrl #(
        .CLEAR_FIRST(1),
        .GAP_CYCLES (1),
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear_req  (clear_req),
        .rwm_done   (rwm_done),
        .rwm_enable (rwm_enable),
        .rwm_rw     (rwm_rw),
        .rwm_clear  (rwm_clear),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .error      (error)
    );

    // RWM model: done during the LEN-th enabled cycle of a phase
    int   act_cnt = 0;
    logic mdl_done = 1'b0;
    logic inj_done = 1'b0;
    logic withhold_wr = 1'b0;

    assign rwm_done = mdl_done | inj_done;

    always @(posedge clk) begin
        #1;
        if (!rwm_enable) begin
            act_cnt  = 0;
            mdl_done = 1'b0;
        end else begin
            act_cnt  = act_cnt + 1;
            mdl_done = (act_cnt == LEN) && !(withhold_wr && rwm_rw);
        end
    end

    typedef struct {
        int kind;
        int arg;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic push(input int k, input int a, input int v);
        ev_t e;
        e.kind = k;
        e.arg  = a;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int cnt);
        push(K_RUN, C_CLR, LEN);
        push(K_LOW, 0, 1);
        push(K_RUN, C_WR, LEN);
        push(K_LOW, 0, 1);
        push(K_RUN, C_RD, LEN);
        push(K_LOW, 0, 1);
        push(K_DONE, 0, cnt);
    endtask

    task automatic emit(input int k, input int a, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d arg=%0d val=%0d expected none", k, a, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.arg != a || e.val != v) begin
                errors++;
                $display("FAIL event: got kind=%0d arg=%0d val=%0d expected kind=%0d arg=%0d val=%0d",
                         k, a, v, e.kind, e.arg, e.val);
            end else begin
                $display("ok   event kind=%0d arg=%0d val=%0d", k, a, v);
            end
        end
    endtask

    // Monitor: enable-high runs, busy enable-low runs, frame completions, error edges
    int   run_len = 0;
    int   run_cmd = 0;
    int   low_len = 0;
    logic done_pend = 1'b0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        int cur_cmd;
        cur_cmd = int'({rwm_clear, rwm_rw});
        if (!rst_n) begin
            run_len   = 0;
            low_len   = 0;
            done_pend = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (run_len > 0 && (!rwm_enable || cur_cmd != run_cmd)) begin
                emit(K_RUN, run_cmd, run_len);
                run_len = 0;
            end
            if (rwm_enable) begin
                if (run_len == 0) run_cmd = cur_cmd;
                run_len++;
            end
            if (low_len > 0 && (rwm_enable || !busy)) begin
                emit(K_LOW, 0, low_len);
                low_len = 0;
            end
            if (!rwm_enable && busy) low_len++;
            if (done_pend) begin
                emit(K_DONE, 0, int'(frame_count));
                done_pend = 1'b0;
            end
            if (frame_done) done_pend = 1'b1;
            if (error != err_prev) begin
                emit(K_ERR, 0, int'(error));
                err_prev = error;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("enable after start", int'(rwm_enable), 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst rwm_enable", int'(rwm_enable), 0);
        check("rst rwm_rw", int'(rwm_rw), 0);
        check("rst rwm_clear", int'(rwm_clear), 0);
        check("rst busy", int'(busy), 0);
        check("rst frame_done", int'(frame_done), 0);
        check("rst frame_count", int'(frame_count), 0);
        check("rst error", int'(error), 0);
        rst_n = 1'b1;

        // plain frame
        push_frame(1);
        pulse_start();
        drain("plain frame pending");

        // clear-only job
        push(K_RUN, C_CLR, LEN);
        push(K_LOW, 0, 1);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        check("clear-only rwm_clear", int'(rwm_clear), 1);
        drain("clear-only pending");
        check("clear-only frame_count", int'(frame_count), 1);

        // start and clear_req together
        push_frame(2);
        @(negedge clk);
        start     = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        clear_req = 1'b0;
        drain("start+clear pending");

        // spurious done in GAP, start re-pulsed during WR
        push_frame(3);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rwm_enable) break;
        end
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rwm_enable && rwm_rw) break;
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ignored inputs pending");

        // counter wrap with CNT_W=2
        push_frame(0);
        pulse_start();
        drain("wrap frame 4 pending");
        push_frame(1);
        pulse_start();
        drain("wrap frame 5 pending");

`ifdef RWM_CTRL_WDOG_EN
        // watchdog: done withheld in WR
        withhold_wr = 1'b1;
        push(K_RUN, C_CLR, LEN);
        push(K_LOW, 0, 1);
        push(K_RUN, C_WR, 8);
        push(K_ERR, 0, 1);
        pulse_start();
        drain("wdog abort pending");
        check("wdog error", int'(error), 1);
        check("wdog enable", int'(rwm_enable), 0);
        check("wdog busy", int'(busy), 0);
        check("wdog frame_count", int'(frame_count), 1);
        withhold_wr = 1'b0;
        push(K_ERR, 0, 0);
        push_frame(2);
        pulse_start();
        drain("wdog recovery pending");
`endif

        // reset asserted mid-WR
        push(K_RUN, C_CLR, LEN);
        push(K_LOW, 0, 1);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rwm_enable && rwm_rw) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset enable", int'(rwm_enable), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset frame_count", int'(frame_count), 0);
        check("midreset error", int'(error), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain("midreset pending");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
